// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state type and the byte-wide CRC32 step.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // Width of the DATA+PAD byte counter; it saturates at all-ones.
  localparam int                CNT_W   = 11;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IPG
  } tx_state_e;

  // Bit reversal, used to derive the LSB-first form of the polynomial.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = bit_rev32(CRC32_POLY);

  // One byte of reflected CRC32 (Ethernet FCS order, LSB of the byte first).
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rgmii_tx_oddr.sv
// Generic stand-in for six vendor DDR output cells (txc, ctl, txd[3:0]).
// Both phases are captured on the rising edge; the pin shows d_rise while the
// clock is high and d_fall while it is low, i.e. one cycle of latency.
module rgmii_tx_oddr (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] d_rise,
  input  logic [5:0] d_fall,
  output logic [5:0] q
);

  logic [5:0] rise_d;
  logic [5:0] fall_d;

  // Phase data is taken straight from the framer registers.
  always_comb begin
    rise_d = d_rise;
    fall_d = d_fall;
  end

  for (genvar i = 0; i < 6; i++) begin : g_oddr
    logic rise_q;
    logic fall_q;

    // One DDR cell: both phases registered on the rising edge.
    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= rise_d[i];
        fall_q <= fall_d[i];
      end
    end

    assign q[i] = gmii_tx_clk ? rise_q : fall_q;
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: wraps a payload stream with preamble, SFD, zero pad
// and FCS, enforces the inter-packet gap and drives the DDR pins.
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int PAD_EN       = 1,
  parameter int IPG_BYTES    = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       rgmii_txc,
  output logic       rgmii_tx_ctl,
  output logic [3:0] rgmii_txd
);

  // The IDLE cycle that sees tx_valid already emits the first preamble byte,
  // so PRE covers the remaining PREAMBLE_LEN-1 bytes.
  localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]       IPG_LAST = 8'(IPG_BYTES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);

  tx_state_e        state_q, state_d;
  logic [7:0]       phase_q, phase_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       gmii_txd_q, gmii_txd_d;
  logic             gmii_tx_en_q, gmii_tx_en_d;
  logic             gmii_tx_er_q, gmii_tx_er_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      fcs;
  logic [7:0]       fcs_byte;
  logic [5:0]       ddr_rise;
  logic [5:0]       ddr_fall;
  logic [5:0]       ddr_q;

  assign tx_ready    = (state_q == ST_DATA);
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;

  // Saturating byte count and the FCS byte selected by the FCS phase.
  always_comb begin
    cnt_inc = (byte_cnt_q == CNT_MAX) ? CNT_MAX : byte_cnt_q + 1'b1;
    fcs     = ~crc_q;
    case (phase_q[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  // Next-state and next-byte logic; one GMII byte is produced per cycle.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    byte_cnt_d   = byte_cnt_q;
    crc_d        = crc_q;
    gmii_txd_d   = 8'h00;
    gmii_tx_en_d = 1'b0;
    gmii_tx_er_d = 1'b0;
    underrun_d   = 1'b0;
    // Registered alongside the GMII byte, so it stays high across the IDLE
    // cycle when the next frame starts straight out of IPG.
    busy_d       = (state_q != ST_IDLE) || tx_valid;

    case (state_q)
      ST_IDLE: begin
        phase_d    = 8'd0;
        byte_cnt_d = '0;
        if (tx_valid) begin
          gmii_txd_d   = ETH_PREAMBLE;
          gmii_tx_en_d = 1'b1;
          phase_d      = 8'd1;
          state_d      = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
        end
      end
      ST_PRE: begin
        gmii_txd_d   = ETH_PREAMBLE;
        gmii_tx_en_d = 1'b1;
        phase_d      = phase_q + 8'd1;
        if (phase_q >= PRE_LAST) begin
          state_d = ST_SFD;
        end
      end
      ST_SFD: begin
        gmii_txd_d   = ETH_SFD;
        gmii_tx_en_d = 1'b1;
        crc_d        = CRC32_INIT;
        byte_cnt_d   = '0;
        state_d      = ST_DATA;
      end
      ST_DATA: begin
        gmii_tx_en_d = 1'b1;
        if (tx_valid) begin
          gmii_txd_d = tx_data;
          crc_d      = crc32_d8(crc_q, tx_data);
          byte_cnt_d = cnt_inc;
          if (tx_last) begin
            phase_d = 8'd0;
            if ((PAD_EN != 0) && (cnt_inc < MIN_CNT)) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
            end
          end
        end else begin
          // Source starved mid-frame: poison the frame and skip the FCS.
          gmii_tx_er_d = 1'b1;
          underrun_d   = 1'b1;
          phase_d      = 8'd0;
          state_d      = ST_IPG;
        end
      end
      ST_PAD: begin
        gmii_txd_d   = 8'h00;
        gmii_tx_en_d = 1'b1;
        crc_d        = crc32_d8(crc_q, 8'h00);
        byte_cnt_d   = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          phase_d = 8'd0;
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        gmii_txd_d   = fcs_byte;
        gmii_tx_en_d = 1'b1;
        phase_d      = phase_q + 8'd1;
        if (phase_q[1:0] == 2'd3) begin
          phase_d = 8'd0;
          state_d = ST_IPG;
        end
      end
      ST_IPG: begin
        phase_d = phase_q + 8'd1;
        if (phase_q >= IPG_LAST) begin
          phase_d = 8'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Framer state, counters, CRC and the registered GMII byte.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 8'd0;
      byte_cnt_q   <= '0;
      crc_q        <= CRC32_INIT;
      gmii_txd_q   <= 8'h00;
      gmii_tx_en_q <= 1'b0;
      gmii_tx_er_q <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_q        <= crc_d;
      gmii_txd_q   <= gmii_txd_d;
      gmii_tx_en_q <= gmii_tx_en_d;
      gmii_tx_er_q <= gmii_tx_er_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  // Bit 5 is the forwarded clock (1 then 0), bit 4 the control line, 3:0 data.
  assign ddr_rise = {1'b1, gmii_tx_en_q, gmii_txd_q[3:0]};
  assign ddr_fall = {1'b0, gmii_tx_en_q ^ gmii_tx_er_q, gmii_txd_q[7:4]};

  rgmii_tx_oddr u_oddr (
    .gmii_tx_clk (gmii_tx_clk),
    .sys_rst_n   (sys_rst_n),
    .d_rise      (ddr_rise),
    .d_fall      (ddr_fall),
    .q           (ddr_q)
  );

  assign rgmii_txc    = ddr_q[5];
  assign rgmii_tx_ctl = ddr_q[4];
  assign rgmii_txd    = ddr_q[3:0];

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: one padding and one non-padding instance
// share the stimulus; a pin monitor rebuilds bytes from both DDR phases.
module tb_rgmii_tx_framer;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;

  logic       rdy_w  [2];
  logic       busy_w [2];
  logic       und_w  [2];
  logic       txc_w  [2];
  logic       ctl_w  [2];
  logic [3:0] txd_w  [2];

  int checks = 0;
  int failures = 0;

  always #4 clk = ~clk;

  rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .PAD_EN(1), .IPG_BYTES(12)) u_pad (
    .gmii_tx_clk (clk),       .sys_rst_n (sys_rst_n),
    .tx_data     (tx_data),   .tx_valid  (tx_valid),   .tx_last (tx_last),
    .tx_ready    (rdy_w[0]),  .tx_busy   (busy_w[0]),  .tx_underrun (und_w[0]),
    .rgmii_txc   (txc_w[0]),  .rgmii_tx_ctl (ctl_w[0]), .rgmii_txd (txd_w[0])
  );

  rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .PAD_EN(0), .IPG_BYTES(12)) u_nopad (
    .gmii_tx_clk (clk),       .sys_rst_n (sys_rst_n),
    .tx_data     (tx_data),   .tx_valid  (tx_valid),   .tx_last (tx_last),
    .tx_ready    (rdy_w[1]),  .tx_busy   (busy_w[1]),  .tx_underrun (und_w[1]),
    .rgmii_txc   (txc_w[1]),  .rgmii_tx_ctl (ctl_w[1]), .rgmii_txd (txd_w[1])
  );

  // ---------------- pin monitor ----------------
  logic [7:0]  mbuf [2][2048];
  int          mlen [2];
  int          merr [2];
  int          idle_cnt [2];
  int          gap_cur [2];
  bit          in_frame [2];
  logic [31:0] tail [2];
  int          nfrm [2];
  int          f_len [2][32];
  int          f_gap [2][32];
  int          f_err [2][32];
  logic [31:0] f_tail [2][32];
  int          ucnt [2];
  int          txc_bad [2];
  int          busy_low [2];
  bit          busy_watch = 1'b0;

  logic       r_ctl [2];
  logic       r_txc [2];
  logic [3:0] r_txd [2];
  logic       r_rst;
  logic [7:0] mon_b;
  logic       mon_en;
  logic       mon_er;

  initial begin
    for (int d = 0; d < 2; d++) begin
      mlen[d] = 0; merr[d] = 0; idle_cnt[d] = 0; gap_cur[d] = 0; in_frame[d] = 1'b0;
      tail[d] = 32'h0; nfrm[d] = 0; ucnt[d] = 0; txc_bad[d] = 0; busy_low[d] = 0;
    end
    forever begin
      @(posedge clk); #1;
      r_rst = sys_rst_n;
      for (int d = 0; d < 2; d++) begin
        r_ctl[d] = ctl_w[d];
        r_txc[d] = txc_w[d];
        r_txd[d] = txd_w[d];
        if (und_w[d]) ucnt[d]++;
        if (busy_watch && !busy_w[d]) busy_low[d]++;
      end
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        mon_b  = {txd_w[d], r_txd[d]};
        mon_en = r_ctl[d];
        mon_er = r_ctl[d] ^ ctl_w[d];
        if (r_rst) begin
          if (!(r_txc[d] === 1'b1 && txc_w[d] === 1'b0)) txc_bad[d]++;
        end else begin
          if (r_txc[d] !== 1'b0 || txc_w[d] !== 1'b0) txc_bad[d]++;
        end
        if (mon_en) begin
          if (!in_frame[d]) begin
            in_frame[d] = 1'b1; mlen[d] = 0; merr[d] = 0; gap_cur[d] = idle_cnt[d];
          end
          if (mlen[d] < 2048) mbuf[d][mlen[d]] = mon_b;
          mlen[d]++;
          if (mon_er) merr[d]++;
          tail[d] = {mon_b, tail[d][31:8]};
        end else begin
          if (in_frame[d]) begin
            if (nfrm[d] < 32) begin
              f_len[d][nfrm[d]]  = mlen[d];
              f_gap[d][nfrm[d]]  = gap_cur[d];
              f_err[d][nfrm[d]]  = merr[d];
              f_tail[d][nfrm[d]] = tail[d];
            end
            nfrm[d]++;
            in_frame[d] = 1'b0;
            idle_cnt[d] = 0;
          end
          idle_cnt[d]++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  logic [7:0] pay  [2048];
  logic [7:0] expb [2048];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: bit-serial reflected CRC32, returns the FCS value.
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ expb[i][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic chk_frame(input int d, input string tag, input int plen, input int padded);
    int k;
    int hdr_bad;
    int body_bad;
    k = nfrm[d] - 1;
    if (k < 0) k = 0;
    if (k > 31) k = 31;
    for (int i = 0; i < padded; i++) expb[i] = (i < plen) ? pay[i] : 8'h00;
    hdr_bad = 0;
    for (int i = 0; i < 7; i++) if (mbuf[d][i] !== 8'h55) hdr_bad++;
    if (mbuf[d][7] !== 8'hD5) hdr_bad++;
    body_bad = 0;
    for (int i = 0; i < padded; i++) if (mbuf[d][8+i] !== expb[i]) body_bad++;
    chk({tag, "_len"},     f_len[d][k], 8 + padded + 4);
    chk({tag, "_hdr_bad"}, hdr_bad, 0);
    chk({tag, "_body_bad"}, body_bad, 0);
    chk({tag, "_fcs"},     f_tail[d][k], ref_fcs(padded));
    chk({tag, "_err"},     f_err[d][k], 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy_w[0] || busy_w[1]) && n < 3000);
    chk({tag, "_idle_timeout"}, (n >= 3000), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Streams pay[0..len-1]; optionally stops early (drop or reset) after
  // the given number of accepted bytes.
  task automatic send(input int len, input bit hold, input int drop_at, input int rst_at);
    int  i;
    int  guard;
    bit  rdy;
    i = 0; guard = 0;
    tx_valid = 1'b1; tx_data = pay[0]; tx_last = (len == 1);
    while (i < len && guard < 4000) begin
      @(negedge clk); rdy = rdy_w[0];
      @(posedge clk); #1; guard++;
      if (rdy) begin
        i++;
        if (i == rst_at) begin
          @(negedge clk); #2;
          sys_rst_n = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
          return;
        end
        if (i == drop_at) begin
          tx_valid = 1'b0; tx_last = 1'b0;
          return;
        end
        if (i < len) begin
          tx_data = pay[i]; tx_last = (i == len - 1);
        end
      end
    end
    chk("send_timeout", (i < len), 0);
    tx_last = 1'b0;
    tx_valid = hold;
  endtask

  int k0;
  int u0;

  // ---------------- directed sequence ----------------
  initial begin
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_pad",   {txc_w[0], ctl_w[0], txd_w[0], rdy_w[0], busy_w[0], und_w[0]}, 0);
    chk("rst_outs_nopad", {txc_w[1], ctl_w[1], txd_w[1], rdy_w[1], busy_w[1], und_w[1]}, 0);
    @(negedge clk); #2 sys_rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_outs", {ctl_w[0], rdy_w[0], busy_w[0], und_w[0], ctl_w[1], busy_w[1]}, 0);

    // Test 1: "123456789", no padding on the PAD_EN=0 instance.
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    tx_valid = 1'b1; tx_data = pay[0];
    @(posedge clk); #1;
    chk("lat_pin_still_idle", ctl_w[1], 1'b0);
    @(posedge clk); #1;
    chk("lat_first_pre", {ctl_w[1], txd_w[1]}, {1'b1, 4'h5});
    send(9, 1'b0, -1, -1);
    wait_idle("t1");
    chk("t1_nfrm_nopad", nfrm[1], 1);
    chk_frame(1, "t1_nopad", 9, 9);
    chk("t1_fcs_const", f_tail[1][0], 32'hCBF43926);
    chk_frame(0, "t1_pad", 9, 60);

    // Test 2: 10-byte payload padded to 60.
    for (int i = 0; i < 10; i++) pay[i] = 8'hA0 + 8'(i);
    send(10, 1'b0, -1, -1);
    wait_idle("t2");
    chk("t2_nfrm_pad", nfrm[0], 2);
    chk_frame(0, "t2_pad", 10, 60);
    chk_frame(1, "t2_nopad", 10, 10);

    // Test 3: two 64-byte frames back to back with tx_valid held high.
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 7 + 3);
    k0 = nfrm[0];
    send(64, 1'b1, -1, -1);
    busy_watch = 1'b1;
    send(64, 1'b0, -1, -1);
    busy_watch = 1'b0;
    wait_idle("t3");
    chk("t3_nfrm", nfrm[0], k0 + 2);
    chk("t3_f1_len", f_len[0][k0], 76);
    for (int i = 0; i < 64; i++) expb[i] = pay[i];
    chk("t3_f1_fcs", f_tail[0][k0], ref_fcs(64));
    chk("t3_gap", f_gap[0][k0+1], 12);
    chk("t3_gap_nopad", f_gap[1][nfrm[1]-1], 12);
    chk("t3_busy_low", busy_low[0], 0);
    chk_frame(0, "t3_f2", 64, 64);

    // Test 4: underrun after 20 bytes, next frame queued during IPG.
    chk("t4_no_prior_underrun", ucnt[0], 0);
    for (int i = 0; i < 64; i++) pay[i] = 8'(i) ^ 8'h5A;
    k0 = nfrm[0];
    u0 = ucnt[0];
    send(64, 1'b0, 20, -1);
    @(posedge clk); #1;
    send(64, 1'b0, -1, -1);
    wait_idle("t4");
    chk("t4_nfrm", nfrm[0], k0 + 2);
    chk("t4_ur_len", f_len[0][k0], 8 + 20 + 1);
    chk("t4_ur_err", f_err[0][k0], 1);
    chk("t4_ur_pulses", ucnt[0] - u0, 1);
    chk("t4_gap_after_ur", f_gap[0][k0+1], 12);
    chk_frame(0, "t4_next", 64, 64);

    // Test 5: reset during DATA byte 30, then a clean frame.
    for (int i = 0; i < 100; i++) pay[i] = 8'hFF - 8'(i);
    k0 = nfrm[0];
    send(100, 1'b0, -1, 30);
    #1;
    chk("t5_rst_outs_pad",   {txc_w[0], ctl_w[0], txd_w[0], rdy_w[0], busy_w[0], und_w[0]}, 0);
    chk("t5_rst_outs_nopad", {txc_w[1], ctl_w[1], txd_w[1], rdy_w[1], busy_w[1], und_w[1]}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 sys_rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_trunc_nfrm", nfrm[0], k0 + 1);
    chk("t5_trunc_len", f_len[0][k0], 8 + 29);
    chk("t5_trunc_err", f_err[0][k0], 0);
    chk("t5_idle_after", {busy_w[0], rdy_w[0], ctl_w[0]}, 0);
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    send(64, 1'b0, -1, -1);
    wait_idle("t5");
    chk_frame(0, "t5_post", 64, 64);
    chk_frame(1, "t5_post_nopad", 64, 64);

    // Test 6: forwarded clock behaviour over the whole run.
    chk("t6_txc_pad",   txc_bad[0], 0);
    chk("t6_txc_nopad", txc_bad[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
